// File: rtl/cmd_packet_rx.sv
`default_nettype none
//==============================================================================
// Module   : cmd_packet_rx
// Purpose  : Copter-side framing stage. Assembles three UART bytes
//            (cmd, data_hi, data_lo) into one command word with a ready/clear
//            handshake, and queues single-byte responses to the UART
//            transmitter through a one-entry pending register.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            rx_rdy, rx_data    - received byte from UART (level until cleared)
//            clr_rx_rdy         - one-cycle pulse clearing rx_rdy
//            cmd_rdy, cmd, data - assembled packet and its valid flag
//            clr_cmd_rdy        - consumer acknowledge
//            resp, send_resp    - response byte and one-cycle send request
//            tx_done            - UART transmitter idle (level)
//            tx_data, trmt      - byte and start pulse to the UART transmitter
//            resp_busy          - response path occupied
//            pkt_err            - pulse when a partial packet is discarded
// Options  : `define PKT_TIMEOUT_EN builds the inter-byte timeout
//            (TIMEOUT_CYCLES, TO_W); otherwise pkt_err is tied low.
// Revision : 1.0 - initial release
//==============================================================================
module cmd_packet_rx #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int TO_W           = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        trmt,
  output logic        resp_busy,
  output logic        pkt_err
);

  typedef enum logic [1:0] {
    WAIT_CMD = 2'd0,
    WAIT_HI  = 2'd1,
    WAIT_LO  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_sh_cmd;
  logic [7:0]  r_sh_hi;
  logic        w_cap;
  logic        w_complete;
  logic        w_start;
  logic        w_timeout;
  logic        r_pending;
  logic [7:0]  r_pend_byte;
  logic        w_drain;

  // rx_rdy is still high during the clear cycle; ignoring it there prevents
  // capturing the same byte twice.
  assign w_cap      = rx_rdy & ~clr_rx_rdy;
  assign w_start    = w_cap & (r_state == WAIT_CMD);
  // The last byte goes straight from rx_data into the output register, so
  // the low data byte needs no separate shadow.
  assign w_complete = w_cap & (r_state == WAIT_LO);

`ifdef PKT_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            r_pkt_err;

  // A capture on the expiry cycle takes priority over the timeout.
  assign w_timeout = (r_state != WAIT_CMD) & ~w_cap &
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign pkt_err   = r_pkt_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_pkt_err <= 1'b0;
    end else begin
      r_pkt_err <= w_timeout;
      if ((r_state == WAIT_CMD) || w_cap || w_timeout)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  // Parameters only matter when the timeout is built; the constant keeps the
  // width relationship visible in both builds.
  localparam logic c_cfg_ok = ((TIMEOUT_CYCLES >> TO_W) == 0);

  assign w_timeout = 1'b0;
  assign pkt_err   = 1'b0 & c_cfg_ok;
`endif

  // RX FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= WAIT_CMD;
    else
      r_state <= w_state_nxt;
  end

  // RX FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (w_cap) begin
      case (r_state)
        WAIT_CMD: w_state_nxt = WAIT_HI;
        WAIT_HI:  w_state_nxt = WAIT_LO;
        default:  w_state_nxt = WAIT_CMD;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = WAIT_CMD;
    end
  end

  // RX datapath: shadows, outputs, handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_rx_rdy <= 1'b0;
      r_sh_cmd   <= '0;
      r_sh_hi    <= '0;
      cmd        <= '0;
      data       <= '0;
      cmd_rdy    <= 1'b0;
    end else begin
      clr_rx_rdy <= w_cap;
      if (w_timeout) begin
        r_sh_cmd <= '0;
        r_sh_hi  <= '0;
      end else if (w_cap) begin
        case (r_state)
          WAIT_CMD: r_sh_cmd <= rx_data;
          WAIT_HI:  r_sh_hi  <= rx_data;
          default: begin
            cmd  <= r_sh_cmd;
            data <= {r_sh_hi, rx_data};
          end
        endcase
      end
      // Completion beats a same-cycle acknowledge; a new packet start drops
      // an unacknowledged one.
      if (w_complete)
        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || w_start)
        cmd_rdy <= 1'b0;
    end
  end

  // Transmitter is considered free once tx_done is seen outside the cycle
  // in which we just started it.
  assign w_drain = resp_busy & tx_done & ~trmt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data     <= '0;
      trmt        <= 1'b0;
      resp_busy   <= 1'b0;
      r_pending   <= 1'b0;
      r_pend_byte <= '0;
    end else begin
      trmt <= 1'b0;
      if (!resp_busy) begin
        if (send_resp) begin
          tx_data   <= resp;
          trmt      <= 1'b1;
          resp_busy <= 1'b1;
        end
      end else if (w_drain) begin
        if (r_pending) begin
          tx_data   <= r_pend_byte;
          trmt      <= 1'b1;
          r_pending <= send_resp;
          if (send_resp)
            r_pend_byte <= resp;
        end else if (send_resp) begin
          // Request arriving as the path frees up goes out directly.
          tx_data <= resp;
          trmt    <= 1'b1;
        end else begin
          resp_busy <= 1'b0;
        end
      end else if (send_resp) begin
        r_pending   <= 1'b1;
        r_pend_byte <= resp;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_packet_rx.sv
`default_nettype none
//==============================================================================
// Module   : tb_cmd_packet_rx
// Purpose  : Directed self-checking bench for cmd_packet_rx. Build with
//            +define+PKT_TIMEOUT_EN to exercise the timeout build
//            (TIMEOUT_CYCLES overridden to 100).
// Revision : 1.0 - initial release
//==============================================================================
module tb_cmd_packet_rx;

`ifdef PKT_TIMEOUT_EN
  localparam int c_TO = 100;
`else
  localparam int c_TO = 2500000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        clr_rx_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = '0;
  logic        send_resp = 1'b0;
  logic        tx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        resp_busy;
  logic        pkt_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_clr    = 0;
  int n_err    = 0;
  logic rdy_at1;

  cmd_packet_rx #(.TIMEOUT_CYCLES(c_TO), .TO_W(22)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .cmd_rdy    (cmd_rdy),
    .cmd        (cmd),
    .data       (data),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .send_resp  (send_resp),
    .tx_done    (tx_done),
    .tx_data    (tx_data),
    .trmt       (trmt),
    .resp_busy  (resp_busy),
    .pkt_err    (pkt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one byte like the UART would; ack raises clr_cmd_rdy in the
  // same cycle. Returns two negedges later; rdy_at1 is cmd_rdy one cycle
  // after the capture edge.
  task automatic send_byte(input logic [7:0] b, input logic ack);
    @(negedge clk);
    rx_data     = b;
    rx_rdy      = 1'b1;
    clr_cmd_rdy = ack;
    @(negedge clk);
    if (clr_rx_rdy) n_clr++;
    rdy_at1     = cmd_rdy;
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    if (clr_rx_rdy) n_clr++;
  endtask

  initial begin
    // Power-up reset, then reset in the middle of a packet
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_byte(8'h02, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_cmd",       32'(cmd),        32'h0);
    check("rst_data",      32'(data),       32'h0);
    check("rst_cmd_rdy",   32'(cmd_rdy),    32'h0);
    check("rst_clr_rx",    32'(clr_rx_rdy), 32'h0);
    check("rst_trmt",      32'(trmt),       32'h0);
    check("rst_tx_data",   32'(tx_data),    32'h0);
    check("rst_resp_busy", 32'(resp_busy),  32'h0);
    check("rst_pkt_err",   32'(pkt_err),    32'h0);
    @(negedge clk);
    rst   = 1'b0;
    n_clr = 0;

    // First packet after reset; stale 0x02 must not appear
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    check("p1_rdy_early", 32'(rdy_at1), 32'h0);
    send_byte(8'h50, 1'b0);
    check("p1_rdy_lat1", 32'(rdy_at1), 32'h1);
    check("p1_cmd",      32'(cmd),     32'h05);
    check("p1_data",     32'(data),    32'h0050);
    check("p1_clr_cnt",  32'(n_clr),   32'd3);

    // Second packet with ack on the completing byte: completion wins
    send_byte(8'h02, 1'b0);
    check("p2_start_clr", 32'(rdy_at1), 32'h0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h90, 1'b1);
    check("p2_ack_vs_done", 32'(rdy_at1), 32'h1);
    repeat (5) @(negedge clk);
    check("p2_hold_rdy",  32'(cmd_rdy), 32'h1);
    check("p2_hold_data", 32'(data),    32'h0090);
    check("p2_hold_cmd",  32'(cmd),     32'h02);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check("p2_ack", 32'(cmd_rdy), 32'h0);

    // Overrun
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h61, 1'b0);
    check("ov_first_rdy",  32'(cmd_rdy), 32'h1);
    check("ov_first_data", 32'(data),    32'h0061);
    send_byte(8'h04, 1'b0);
    check("ov_drop_rdy", 32'(rdy_at1), 32'h0);
    check("ov_cmd_held", 32'(cmd),     32'h03);
    send_byte(8'h00, 1'b0);
    send_byte(8'h3B, 1'b0);
    check("ov_rdy",  32'(cmd_rdy), 32'h1);
    check("ov_cmd",  32'(cmd),     32'h04);
    check("ov_data", 32'(data),    32'h003B);

    // Response path
    @(negedge clk);
    resp = 8'hA5; send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    check("r_trmt1",   32'(trmt),      32'h1);
    check("r_tx_a5",   32'(tx_data),   32'hA5);
    check("r_busy1",   32'(resp_busy), 32'h1);
    @(negedge clk);
    check("r_trmt1_end", 32'(trmt), 32'h0);
    resp = 8'h12; send_resp = 1'b1;
    @(negedge clk);
    resp = 8'h34;
    @(negedge clk);
    send_resp = 1'b0;
    check("r_pend_trmt", 32'(trmt),    32'h0);
    check("r_pend_tx",   32'(tx_data), 32'hA5);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("r_trmt2", 32'(trmt),    32'h1);
    check("r_tx_34", 32'(tx_data), 32'h34);
    @(negedge clk);
    check("r_busy2", 32'(resp_busy), 32'h1);
    check("r_trmt2_end", 32'(trmt),  32'h0);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("r_idle",    32'(resp_busy), 32'h0);
    check("r_no_trmt", 32'(trmt),      32'h0);

    // Stalled packet
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    send_byte(8'h06, 1'b0);
    send_byte(8'h87, 1'b0);
`ifdef PKT_TIMEOUT_EN
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (pkt_err) n_err++;
    end
    check("to_err_cnt", 32'(n_err),   32'd1);
    check("to_rdy",     32'(cmd_rdy), 32'h0);
    check("to_cmd",     32'(cmd),     32'h04);
    check("to_data",    32'(data),    32'h003B);
    send_byte(8'h07, 1'b0);
    send_byte(8'h52, 1'b0);
    send_byte(8'h52, 1'b0);
    check("to_new_rdy",  32'(cmd_rdy), 32'h1);
    check("to_new_cmd",  32'(cmd),     32'h07);
    check("to_new_data", 32'(data),    32'h5252);
`else
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (pkt_err) n_err++;
    end
    check("st_err_cnt", 32'(n_err),   32'd0);
    check("st_rdy",     32'(cmd_rdy), 32'h0);
    send_byte(8'h89, 1'b0);
    check("st_rdy_done", 32'(cmd_rdy), 32'h1);
    check("st_cmd",      32'(cmd),     32'h06);
    check("st_data",     32'(data),    32'h8789);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmd_packet_rx.md
Name: cmd_packet_rx

Overview:
- Copter-side framing stage between the UART transceiver and the command-config block.
- Assembles 3 received UART bytes (cmd, data_hi, data_lo) into one command word, presents it with a ready/clear handshake, and queues 1-byte responses (e.g. 8'hA5 ack, battery byte) back to the UART transmitter.
- Downstream of the UART, upstream of command decode.

Parameters:
- TIMEOUT_CYCLES, 2500000: inter-byte timeout in clk cycles (50 ms at 50 MHz). Used only with PKT_TIMEOUT_EN.
- TO_W, 22: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_rdy  in  1  UART has a received byte; level, held until cleared
- rx_data  in  8  received byte
- clr_rx_rdy  out  1  one-cycle pulse that knocks down rx_rdy
- cmd_rdy  out  1  complete packet available
- cmd  out  8  packet opcode
- data  out  16  packet data {byte1, byte2}
- clr_cmd_rdy  in  1  consumer acknowledges the packet
- resp  in  8  response byte to send
- send_resp  in  1  one-cycle request to send resp
- tx_done  in  1  UART transmitter idle/finished; level
- tx_data  out  8  byte to the UART transmitter
- trmt  out  1  one-cycle start pulse to the UART transmitter
- resp_busy  out  1  response path is occupied (transmitting or holding a pending byte)
- pkt_err  out  1  one-cycle pulse when a partial packet is discarded

Behaviour:
- Async active-high reset forces: state=WAIT_CMD, cmd=0, data=0, cmd_rdy=0, clr_rx_rdy=0, trmt=0, tx_data=0, resp_busy=0, pkt_err=0, pending=0, timeout counter=0.
- RX FSM states: WAIT_CMD -> WAIT_HI -> WAIT_LO -> WAIT_CMD. A state advances only on a cycle where rx_rdy=1.
- Byte capture: on a cycle with rx_rdy=1, capture rx_data into a shadow register and drive clr_rx_rdy=1 for the next cycle only. rx_rdy is ignored on the cycle clr_rx_rdy is high, so no double capture occurs.
- Shadow registers: byte 0 -> shadow cmd; byte 1 -> shadow data[15:8]; byte 2 -> shadow data[7:0].
- Output update: cmd and data update only on completion and are stable while cmd_rdy=1.
- Completion: on the cycle after byte 2 is captured, cmd/data load from the shadows and cmd_rdy=1. Latency from byte-2 rx_rdy to cmd_rdy is 1 cycle.
- cmd_rdy clears on clr_cmd_rdy, or when byte 0 of the next packet is captured (overrun: the old packet is dropped silently).
- Simultaneous clr_cmd_rdy and completion: completion wins, so cmd_rdy=1.
- Response path, when idle (resp_busy=0): send_resp loads tx_data=resp and pulses trmt on the next cycle; resp_busy=1.
- Response path, when busy: send_resp stores resp in a 1-entry pending register. A second send_resp while pending=1 overwrites the pending byte (last wins).
- Response drain: when tx_done=1 and the cycle is not the trmt cycle itself:
  - pending=1: issue the pending byte with trmt and clear pending.
  - pending=0: resp_busy=0.
- Response path and RX FSM are independent; simultaneous events on both are handled in the same cycle.

Optional Feature:
- Macro: PKT_TIMEOUT_EN.
- Defined:
  - The counter resets to 0 on every byte capture and in WAIT_CMD.
  - It increments each cycle while in WAIT_HI or WAIT_LO.
  - On reaching TIMEOUT_CYCLES-1: the FSM returns to WAIT_CMD, shadows are discarded, pkt_err pulses 1 cycle, and cmd_rdy/cmd/data are unchanged.
- Not defined: no counter is built, pkt_err is tied 0, and the FSM waits indefinitely for bytes.

Test Plan:
- Reset mid-packet (after byte 0x02 only) -> all outputs 0. Then bytes 0x05,0x00,0x50 -> cmd=8'h05, data=16'h0050, cmd_rdy=1 one cycle after the 3rd byte; clr_rx_rdy pulses exactly 3 times.
- Packet 0x02,0x00,0x90; hold clr_cmd_rdy low -> cmd_rdy stays 1 and data holds 16'h0090; pulse clr_cmd_rdy -> cmd_rdy=0 next cycle.
- Overrun: packet 0x03/0x0061 left unacknowledged, then byte 0x04 arrives -> cmd_rdy=0 at capture; after 0x00,0x3B -> cmd=8'h04, data=16'h003B.
- send_resp with resp=8'hA5, tx_done held 0 -> tx_data=A5 and one trmt pulse. Then send_resp 0x12 and send_resp 0x34 while busy; raise tx_done -> second trmt with tx_data=8'h34; resp_busy=0 after the next tx_done.
- With PKT_TIMEOUT_EN and TIMEOUT_CYCLES=100: bytes 0x06,0x87 then idle 100 cycles -> pkt_err pulse and cmd_rdy stays 0. Then 0x07,0x52,0x52 -> cmd=8'h07, data=16'h5252.
- Without PKT_TIMEOUT_EN: same stall for 10000 cycles -> no pkt_err; a following byte 0x89 completes the packet as cmd=8'h06, data=16'h8789.
